// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 inter-stage pipeline registers: skid state
// encoding, per-stage payload layouts, widths and reset payloads.
package pipe_pkg;

    // Occupancy state of a skid-enabled stage register.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_MAIN  = 2'd1,
        PS_BOTH  = 2'd2
    } pipe_state_e;

    // IF/ID: fetched instruction and its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // ID/EX: operands, immediate and decoded control.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        load_signed;
        logic        reg_wr;
    } id_ex_t;

    // EX/MEM: ALU result, store data and memory control.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  load_size;
        logic        load_signed;
        logic        reg_wr;
    } ex_mem_t;

    // MEM/WB: write-back value and destination.
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    // A killed fetch slot decodes as the canonical NOP (addi x0, x0, 0).
    localparam if_id_t IF_ID_RST_S = '{pc: 32'h0, instr: 32'h0000_0013};

    localparam id_ex_t ID_EX_RST_S = '{
        pc: 32'h0, rs1_val: 32'h0, rs2_val: 32'h0, imm: 32'h0, rd: 5'd0,
        alu_op: 4'd0, alu_src_imm: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0,
        mem_size: 2'b10, load_signed: 1'b1, reg_wr: 1'b0
    };

    // Idle memory stage presents a word-sized signed access with no enables.
    localparam ex_mem_t EX_MEM_RST_S = '{
        alu_result: 32'h0, store_data: 32'h0, rd: 5'd0, mem_rd: 1'b0,
        mem_wr: 1'b0, load_size: 2'b10, load_signed: 1'b1, reg_wr: 1'b0
    };

    localparam mem_wb_t MEM_WB_RST_S = '{wb_data: 32'h0, rd: 5'd0, reg_wr: 1'b0};

    localparam logic [IF_ID_W-1:0]  IF_ID_RST  = IF_ID_RST_S;
    localparam logic [ID_EX_W-1:0]  ID_EX_RST  = ID_EX_RST_S;
    localparam logic [EX_MEM_W-1:0] EX_MEM_RST = EX_MEM_RST_S;
    localparam logic [MEM_WB_W-1:0] MEM_WB_RST = MEM_WB_RST_S;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register plus valid flag. Used for both the main and the skid
// entry of pipe_stage_reg. A clear drops the valid and, when CLR_ON_FLUSH is
// set, reloads the payload with RST_VAL.
module pipe_skid_slot #(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] RST_VAL      = {DATA_W{1'b0}},
    parameter bit                CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              valid_d_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Valid follows the parent's next-state; payload only moves on a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            if (CLR_ON_FLUSH) begin
                data_q <= RST_VAL;
            end
        end else begin
            valid_q <= valid_d_i;
            if (wr_en_i) begin
                data_q <= wr_data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register between RV32 core stages.
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry that
// registers in_ready and breaks the out_ready -> in_ready combinational path.
// Without it the stage is a single register with full throughput.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] RST_VAL      = {DATA_W{1'b0}},
    parameter bit                CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_valid_d;
    logic              main_wr_en;
    logic [DATA_W-1:0] main_wr_data;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    pipe_skid_slot #(
        .DATA_W       (DATA_W),
        .RST_VAL      (RST_VAL),
        .CLR_ON_FLUSH (CLR_ON_FLUSH)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .valid_d_i (main_valid_d),
        .wr_en_i   (main_wr_en),
        .wr_data_i (main_wr_data),
        .valid_o   (out_valid),
        .data_o    (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              in_ready_q;
    logic              skid_valid;
    logic              skid_wr_en;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_slot #(
        .DATA_W       (DATA_W),
        .RST_VAL      (RST_VAL),
        .CLR_ON_FLUSH (CLR_ON_FLUSH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .valid_d_i (state_d == PS_BOTH),
        .wr_en_i   (skid_wr_en),
        .wr_data_i (in_data),
        .valid_o   (skid_valid),
        .data_o    (skid_data)
    );

    // Route the accepted word to main or skid; skid always drains through main.
    always_comb begin
        state_d      = state_q;
        main_wr_en   = 1'b0;
        main_wr_data = in_data;
        skid_wr_en   = 1'b0;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        main_wr_en = 1'b1;
                        state_d    = PS_MAIN;
                    end
                end
                PS_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_wr_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_wr_en = 1'b1;
                        state_d    = PS_BOTH;
                    end else if (out_xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_BOTH: begin
                    if (out_xfer) begin
                        main_wr_en   = 1'b1;
                        main_wr_data = skid_data;
                        state_d      = PS_MAIN;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    assign main_valid_d = (state_d != PS_EMPTY);

    // Occupancy state and registered in_ready (low only while the skid is full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PS_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != PS_BOTH);
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

`else

    // Single register: accept whenever the held word is absent or leaving.
    always_comb begin
        in_ready     = ~out_valid | out_ready;
        main_wr_en   = in_xfer;
        main_wr_data = in_data;
        main_valid_d = in_xfer | (out_valid & ~out_ready);
    end

    assign occupancy = {1'b0, out_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg. Two instances share stimulus: one
// clears the payload on flush, one keeps it. A queue holds the words the
// stage should be carrying; the head is what must be on out_data.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hDEAD_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, nc_in_ready, nc_out_valid;
    logic [31:0] out_data, nc_out_data;
    logic [1:0]  occupancy, nc_occupancy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] q[$];
    logic [31:0] idle_c = RV;
    logic [31:0] idle_n = RV;
    logic        exp_rdy = 1'b1;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_d = '0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .RST_VAL(RV), .CLR_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .RST_VAL(RV), .CLR_ON_FLUSH(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nc_in_ready),
        .in_data(in_data), .out_valid(nc_out_valid), .out_ready(out_ready),
        .out_data(nc_out_data), .occupancy(nc_occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Monitor: compare the stage against the queue head, then retire on transfer.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
`ifdef PIPE_STAGE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || out_ready;
`endif
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("out_data", out_data, (q.size() != 0) ? q[0] : idle_c);
            chk("occupancy", 32'(occupancy), q.size());
            chk("nc_in_ready", 32'(nc_in_ready), 32'(exp_rdy));
            chk("nc_out_valid", 32'(nc_out_valid), 32'(q.size() != 0));
            chk("nc_out_data", nc_out_data, (q.size() != 0) ? q[0] : idle_n);
            chk("nc_occupancy", 32'(nc_occupancy), q.size());
            if (hold_prev) begin
                chk("stable_valid", 32'(out_valid), 32'h1);
                chk("stable_data", out_data, prev_d);
            end
            hold_prev = out_valid && !out_ready && !flush;
            prev_d    = out_data;
            if (q.size() != 0) begin
                idle_c = q[0];
                idle_n = q[0];
                if (out_ready && !flush) void'(q.pop_front());
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Stimulus recorder: push accepted words, drop everything on flush.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (flush) begin
                q.delete();
                idle_c = RV;
            end else if (in_valid && exp_rdy) begin
                q.push_back(in_data);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, RV);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a transfer.
        drive(1, 32'h1234, 0, 0);
        drive(1, 32'h1234, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_out_data", out_data, RV);
        chk("async_occupancy", 32'(occupancy), 32'h0);
        chk("async_nc_out_data", nc_out_data, RV);
        q.delete();
        idle_c = RV;
        idle_n = RV;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back streaming.
        for (int i = 1; i <= 4; i++) drive(1, 32'(i), 1, 0);
        repeat (3) drive(0, 32'h0, 1, 0);

        // Stall, then release.
        drive(1, 32'hA5A5, 0, 0);
        drive(1, 32'h5A5A, 0, 0);
        repeat (2) drive(1, 32'h6B6B, 0, 0);
        repeat (3) drive(0, 32'h0, 1, 0);

        // Flush with the stage full and a word arriving.
        drive(1, 32'h11, 0, 0);
        drive(1, 32'h22, 0, 0);
        drive(1, 32'h77, 0, 1);
        repeat (2) drive(0, 32'h0, 1, 0);
        drive(1, 32'h33, 1, 0);
        drive(0, 32'h0, 1, 1);
        drive(0, 32'h0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 10) < 7, $urandom, ($urandom % 10) < 6, ($urandom % 40) == 0);
        end
        repeat (4) drive(0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
